axis_bus_arbiter: RTL and testbench
===================================

Name: axis_bus_arbiter

Overview:
- Packet-level round-robin arbiter that generates `bus_sel` for the downstream `axis_bus_demux` (tready routing) and the matching tdata/tvalid mux.
- Selects one of N source FIFOs with data pending and holds the selection for a whole AXI-stream packet, until the tlast handshake.
- Inserts one idle cycle between packets.
- A watchdog releases the grant if a selected source stalls.

Parameters:
- N_FIFO, 4, number of source FIFOs (1..127).
- TIMEOUT, 1024, maximum consecutive grant cycles without a beat handshake before forced release (>=2).
- CNT_W, 16, width of the packet beat counter and the watchdog counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- fifo_req  input  N_FIFO  bit i high = FIFO i non-empty / holding a packet.
- axis_in_tvalid  input  1  tvalid of the muxed (selected) stream.
- axis_in_tready  input  1  tready from the downstream sink.
- axis_in_tlast  input  1  tlast of the muxed stream.
- bus_sel  output  8  selection code to demux/mux: 0 = none, 128+i = FIFO i.
- grant_active  output  1  high while a FIFO is selected.
- pkt_done  output  1  one-cycle pulse on tlast handshake of the granted packet.
- pkt_beats  output  CNT_W  beat count of the last completed packet, held until the next completion.
- timeout_err  output  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Reset values:
  - bus_sel=0, grant_active=0, pkt_done=0, pkt_beats=0, timeout_err=0.
  - Round-robin pointer = N_FIFO-1, so FIFO 0 has first priority.
  - State = IDLE, counters = 0.
- Beat definition: beat = axis_in_tvalid & axis_in_tready while in GRANT.
- State IDLE (bus_sel=0):
  - If any fifo_req bit is set, pick the first set bit searching from pointer+1 upward with wrap-around.
  - Register bus_sel=128+idx and grant_active=1 next cycle; go to GRANT; pointer <= idx.
  - Latency from fifo_req to bus_sel is one clock.
- State GRANT:
  - bus_sel is held constant; fifo_req changes are ignored, including deassertion of the granted bit.
  - Each beat increments beat_cnt, saturating at all-ones, and clears the watchdog.
  - A non-beat cycle increments the watchdog.
  - Beat with tlast:
    - pkt_done=1 and pkt_beats=beat_cnt+1 (saturated) next cycle.
    - bus_sel=0, grant_active=0; go to GAP; beat_cnt cleared.
  - Watchdog reaches TIMEOUT-1 with no beat that cycle:
    - timeout_err=1 next cycle.
    - bus_sel=0, grant_active=0; go to GAP.
    - pkt_beats and pkt_done are unchanged.
  - Simultaneous tlast beat and watchdog expiry: the beat wins (normal completion, no timeout_err).
- State GAP:
  - Exactly one cycle with bus_sel=0, then IDLE.
  - Minimum spacing between consecutive grants: the cycle after tlast (GAP), then IDLE, then bus_sel new. Two cycles of bus_sel=0.
- Fairness: the granted index becomes the lowest priority for the next arbitration.
- Codes other than 0 and 128..128+N_FIFO-1 are never produced.
- Reset asserted mid-packet:
  - All outputs return to reset values immediately (asynchronous).
  - The pointer is restored to N_FIFO-1.
  - The interrupted packet is not reported.
- Single-beat packet (tvalid, tready and tlast on the first GRANT cycle): pkt_beats=1.

Decomposition:
- Shared package axis_bus_pkg holds:
  - NON_FIFO_CHOOSE=8'd0.
  - CHOOSE_BASE=8'd128.
  - State encoding: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - Helper function sel_code(idx) = CHOOSE_BASE + idx.
- One sub-module, rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: req vector and pointer. Outputs: idx and found.
- FSM, counters and output registers live in axis_bus_arbiter.

Test Plan:
- Reset then fifo_req=4'b0100 -> one cycle later bus_sel=130 and grant_active=1. A 3-beat packet with tlast on beat 3 -> pkt_done pulse, pkt_beats=3, bus_sel=0 for 2 cycles.
- fifo_req=4'b1111 held, 1-beat packets each -> grant order 128,129,130,131,128, with each grant separated by 2 idle cycles.
- Grant FIFO 1, then tvalid=1 and tready=0 for TIMEOUT cycles -> timeout_err pulse exactly at TIMEOUT cycles after the last beat, bus_sel=0, pkt_beats unchanged. Next arbitration starts from FIFO 2.
- fifo_req granted bit drops mid-packet -> bus_sel held until the tlast handshake. tvalid=1 with tready=0 on tlast -> no completion until tready=1.
- Assert rst for 1 cycle mid-packet (beat 2 of 5) -> outputs zero asynchronously. After release with fifo_req=4'b0011 -> FIFO 0 granted (bus_sel=128).
- tlast beat on the same cycle the watchdog expires -> pkt_done=1, timeout_err=0.

Source files
------------

// File: rtl/axis_bus_pkg.sv
// Shared selection codes, FSM encoding and helpers for the packet-level AXI-stream arbiter.
// The selection code drives both the tready demux and the tdata/tvalid mux downstream.
package axis_bus_pkg;

    localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;
    localparam logic [7:0] CHOOSE_BASE     = 8'd128;
    // Wide enough for the largest supported source count (127).
    localparam int         IDX_W           = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [7:0] sel_code(input logic [IDX_W-1:0] idx);
        return CHOOSE_BASE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/axis_bus_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request strictly after ptr, with wrap-around.
// The source at ptr itself is searched last, so it has the lowest priority.
module rr_pick
    import axis_bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rot;
    logic [IDX_W:0]   sum;

    always_comb begin
        start = (ptr >= IDX_W'(N - 1)) ? '0 : ptr + IDX_W'(1);
        // Rotate so that bit 0 of rot corresponds to source 'start'.
        rot   = N'({req, req} >> start);
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        // Descending scan: the lowest set bit of rot is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, start} + (IDX_W + 1)'(i);
                if (sum >= (IDX_W + 1)'(N)) begin
                    sum = sum - (IDX_W + 1)'(N);
                end
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_bus_arbiter.sv
// Packet-level round-robin arbiter: holds one source for a whole AXI-stream packet,
// inserts one idle cycle between packets and releases a stalled grant via a watchdog.
module axis_bus_arbiter
    import axis_bus_pkg::*;
#(
    parameter int N_FIFO  = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_FIFO-1:0] fifo_req,
    input  logic              axis_in_tvalid,
    input  logic              axis_in_tready,
    input  logic              axis_in_tlast,
    output logic [7:0]        bus_sel,
    output logic              grant_active,
    output logic              pkt_done,
    output logic [CNT_W-1:0]  pkt_beats,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] wdog;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic             beat;
    logic             done_hit;
    logic             wd_hit;

    rr_pick #(.N(N_FIFO)) u_pick (
        .req   (fifo_req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A beat is a cycle where the selected stream has tvalid and the sink has tready
    // while granted; tvalid may be held without tready indefinitely (watchdog applies).
    assign beat         = (state == GRANT) && axis_in_tvalid && axis_in_tready;
    assign done_hit     = beat && axis_in_tlast;
    assign wd_hit       = (state == GRANT) && !beat && (wdog == WD_LAST);
    assign beat_cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = GRANT;
            GRANT:   if (done_hit || wd_hit) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The pointer always equals the granted index while in GRANT.
    always_comb begin
        bus_sel      = NON_FIFO_CHOOSE;
        grant_active = 1'b0;
        if (state == GRANT) begin
            bus_sel      = sel_code(ptr);
            grant_active = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= IDX_W'(N_FIFO - 1);
            beat_cnt    <= '0;
            wdog        <= '0;
            pkt_done    <= 1'b0;
            pkt_beats   <= '0;
            timeout_err <= 1'b0;
        end else begin
            pkt_done    <= done_hit;
            timeout_err <= wd_hit;
            if (state == IDLE && pick_found) begin
                ptr <= pick_idx;
            end
            if (done_hit) begin
                pkt_beats <= beat_cnt_inc;
            end
            if (state == GRANT && !done_hit) begin
                if (beat) begin
                    beat_cnt <= beat_cnt_inc;
                    wdog     <= '0;
                end else begin
                    wdog     <= wdog + CNT_ONE;
                end
            end else begin
                beat_cnt <= '0;
                wdog     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_bus_arbiter.sv
// Bench for axis_bus_arbiter: vector tables, hand-written corner sequences and a
// randomized run against a transaction-style reference model.
module tb_axis_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] fifo_req;
    logic         axis_in_tvalid;
    logic         axis_in_tready;
    logic         axis_in_tlast;
    logic [7:0]   bus_sel;
    logic         grant_active;
    logic         pkt_done;
    logic [15:0]  pkt_beats;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  req;
        logic        tv, tr, tl;
        logic [7:0]  sel;
        logic        ga, done;
        logic [15:0] beats;
        logic        to;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];

    // reference model state
    int          m_owner, m_last, m_rest, m_cnt, m_stall;
    logic [7:0]  m_sel;
    logic        m_done, m_to;

    axis_bus_arbiter #(.N_FIFO(N), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_req       (fifo_req),
        .axis_in_tvalid (axis_in_tvalid),
        .axis_in_tready (axis_in_tready),
        .axis_in_tlast  (axis_in_tlast),
        .bus_sel        (bus_sel),
        .grant_active   (grant_active),
        .pkt_done       (pkt_done),
        .pkt_beats      (pkt_beats),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic v, input logic t, input logic l);
        fifo_req       = r;
        axis_in_tvalid = v;
        axis_in_tready = t;
        axis_in_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fifo_req       = '0;
        axis_in_tvalid = 1'b0;
        axis_in_tready = 1'b0;
        axis_in_tlast  = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic [3:0] r, input logic v, input logic t, input logic l,
                           input logic [7:0] s, input logic g, input logic d,
                           input logic [15:0] b, input logic o);
        vec_t x;
        x.req = r; x.tv = v; x.tr = t; x.tl = l;
        x.sel = s; x.ga = g; x.done = d; x.beats = b; x.to = o;
        vecs.push_back(x);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].tv, vecs[i].tr, vecs[i].tl);
            chk($sformatf("%s%0d_sel", tag, i), bus_sel, vecs[i].sel);
            chk($sformatf("%s%0d_ga", tag, i), grant_active, vecs[i].ga);
            chk($sformatf("%s%0d_done", tag, i), pkt_done, vecs[i].done);
            chk($sformatf("%s%0d_beats", tag, i), pkt_beats, vecs[i].beats);
            chk($sformatf("%s%0d_to", tag, i), timeout_err, vecs[i].to);
        end
        vecs.delete();
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_rest  = 0;
        m_cnt   = 0;
        m_stall = 0;
        m_sel   = 8'd0;
        m_done  = 1'b0;
        m_to    = 1'b0;
    endtask

    // Packet-level view: an owner, its beat and stall counts, and a one-cycle rest after release.
    task automatic model_step(input logic [3:0] r, input logic v, input logic t, input logic l);
        m_done = 1'b0;
        m_to   = 1'b0;
        if (m_owner >= 0) begin
            if (v && t) begin
                if (m_cnt < 65535) m_cnt++;
                m_stall = 0;
                if (l) begin
                    m_done  = 1'b1;
                    exp_q.push_back(16'(m_cnt));
                    m_owner = -1;
                    m_rest  = 1;
                end
            end else begin
                m_stall++;
                if (m_stall == TO) begin
                    m_to    = 1'b1;
                    m_owner = -1;
                    m_rest  = 1;
                end
            end
        end else if (m_rest > 0) begin
            m_rest--;
        end else if (r != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (((r >> c) & 4'd1) != 0) begin
                    m_owner = c;
                    break;
                end
            end
            m_last  = m_owner;
            m_cnt   = 0;
            m_stall = 0;
        end
        m_sel = (m_owner >= 0) ? 8'(128 + m_owner) : 8'd0;
    endtask

    initial begin
        rst            = 1'b1;
        fifo_req       = '0;
        axis_in_tvalid = 1'b0;
        axis_in_tready = 1'b0;
        axis_in_tlast  = 1'b0;
        #3;
        chk("rst_sel", bus_sel, 8'd0);
        chk("rst_ga", grant_active, 1'b0);
        chk("rst_done", pkt_done, 1'b0);
        chk("rst_beats", pkt_beats, 16'd0);
        chk("rst_to", timeout_err, 1'b0);
        do_reset();

        // single source, 3-beat packet, then a 1-beat packet after the two idle cycles
        add_vec(4'b0100, 0, 0, 0, 8'd130, 1, 0, 16'd0, 0);
        add_vec(4'b0100, 1, 1, 0, 8'd130, 1, 0, 16'd0, 0);
        add_vec(4'b0100, 1, 1, 0, 8'd130, 1, 0, 16'd0, 0);
        add_vec(4'b0100, 1, 1, 1, 8'd0,   0, 1, 16'd3, 0);
        add_vec(4'b0100, 0, 0, 0, 8'd0,   0, 0, 16'd3, 0);
        add_vec(4'b0100, 0, 0, 0, 8'd130, 1, 0, 16'd3, 0);
        add_vec(4'b0000, 1, 1, 1, 8'd0,   0, 1, 16'd1, 0);
        add_vec(4'b0000, 0, 0, 0, 8'd0,   0, 0, 16'd1, 0);
        add_vec(4'b0000, 0, 0, 0, 8'd0,   0, 0, 16'd1, 0);
        run_vecs("one");

        // all sources requesting, 1-beat packets: rotation 128,129,130,131,128
        do_reset();
        for (int g = 0; g < 5; g++) begin
            add_vec(4'b1111, 1, 1, 1, 8'(128 + (g % N)), 1, 0, (g == 0) ? 16'd0 : 16'd1, 0);
            add_vec(4'b1111, 1, 1, 1, 8'd0, 0, 1, 16'd1, 0);
            add_vec(4'b1111, 1, 1, 1, 8'd0, 0, 0, 16'd1, 0);
        end
        run_vecs("rr");

        // watchdog release on FIFO 1 after a 2-beat packet on FIFO 0
        do_reset();
        step(4'b0011, 0, 0, 0); chk("to_g0", bus_sel, 8'd128);
        step(4'b0011, 1, 1, 0);
        step(4'b0011, 1, 1, 1); chk("to_p0_done", pkt_done, 1'b1); chk("to_p0_beats", pkt_beats, 16'd2);
        step(4'b0010, 0, 0, 0); chk("to_gap", bus_sel, 8'd0);
        step(4'b0010, 0, 0, 0); chk("to_g1", bus_sel, 8'd129);
        step(4'b0010, 1, 1, 0); chk("to_beat", bus_sel, 8'd129);
        for (int i = 1; i < TO; i++) begin
            step(4'b0000, 1, 0, 0);
            chk($sformatf("to_hold%0d", i), {bus_sel, timeout_err}, {8'd129, 1'b0});
        end
        step(4'b0000, 1, 0, 0);
        chk("to_err", timeout_err, 1'b1);
        chk("to_sel", bus_sel, 8'd0);
        chk("to_ga", grant_active, 1'b0);
        chk("to_done", pkt_done, 1'b0);
        chk("to_beats", pkt_beats, 16'd2);
        step(4'b1111, 0, 0, 0); chk("to_pulse", timeout_err, 1'b0); chk("to_gap2", bus_sel, 8'd0);
        step(4'b1111, 0, 0, 0); chk("to_next", bus_sel, 8'd130);

        // granted request drops mid-packet; tlast held without tready
        step(4'b0000, 1, 1, 0); chk("drop_b1", bus_sel, 8'd130);
        step(4'b0000, 1, 1, 0); chk("drop_b2", bus_sel, 8'd130);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1, 0, 1);
            chk($sformatf("drop_wait%0d", i), {bus_sel, pkt_done}, {8'd130, 1'b0});
        end
        step(4'b0000, 1, 1, 1);
        chk("drop_done", pkt_done, 1'b1);
        chk("drop_beats", pkt_beats, 16'd3);
        chk("drop_sel", bus_sel, 8'd0);
        step(4'b0000, 0, 0, 0);

        // tlast beat on the cycle the watchdog would expire
        step(4'b1111, 0, 0, 0); chk("sim_g", bus_sel, 8'd131);
        for (int i = 1; i < TO; i++) step(4'b1111, 0, 0, 0);
        chk("sim_hold", bus_sel, 8'd131);
        step(4'b1111, 1, 1, 1);
        chk("sim_done", pkt_done, 1'b1);
        chk("sim_to", timeout_err, 1'b0);
        chk("sim_beats", pkt_beats, 16'd1);
        step(4'b0000, 0, 0, 0); chk("sim_to2", timeout_err, 1'b0);

        // asynchronous reset in the middle of a packet on FIFO 0
        step(4'b0001, 0, 0, 0); chk("rs_g", bus_sel, 8'd128);
        step(4'b0000, 1, 1, 0);
        step(4'b0000, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("rs_sel", bus_sel, 8'd0);
        chk("rs_ga", grant_active, 1'b0);
        chk("rs_beats", pkt_beats, 16'd0);
        chk("rs_done", pkt_done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b0011, 0, 0, 0); chk("rs_after", bus_sel, 8'd128);
        step(4'b0000, 1, 1, 1); chk("rs_beats1", pkt_beats, 16'd1);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] r;
            logic       v, t, l;
            r = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            t = ((cyc % 256) < 40) ? 1'b0 : 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 3) == 0);
            step(r, v, t, l);
            model_step(r, v, t, l);
            chk("rand_sel", bus_sel, m_sel);
            chk("rand_ga", grant_active, (m_owner >= 0));
            chk("rand_done", pkt_done, m_done);
            chk("rand_to", timeout_err, m_to);
            if (pkt_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rand_sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("rand_beats", pkt_beats, exp_q.pop_front());
                end
            end
        end
        chk("rand_sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
